seg_scan_ctrl: RTL

Time-multiplexed scanner that shares a single `bcd7seg` hex decoder across `DIGITS` common-anode 7-segment digits. Producers load a packed nibble word through a valid/ready handshake. The block double-buffers it and commits only at frame boundaries, so the display never tears. It sits between the SoC's debug/status registers and the board display pins.

---
 rtl/seg_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner sharing one bcd7seg decoder across DIGITS digits.
// Define SEG_SCAN_LZS_EN to enable leading-zero suppression.
//   state | meaning
//   BLANK | no word committed since reset; counters run, all digits off
//   SCAN  | committed word is scanned out digit by digit

module bcd7seg (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end
endmodule

module seg_scan_ctrl #(
   parameter int DIGITS = 8,
   parameter int DIV    = 1000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [4*DIGITS-1:0]   upd_data,
   input  logic [DIGITS-1:0]     upd_mask,
   output logic [6:0]            seg_out,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_done
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic {BLANK, SCAN} state_t;

   state_t                state_q, state_d;
   logic [DW-1:0]         div_cnt;
   logic [IW-1:0]         idx;
   logic                  pend_vld;
   logic [4*DIGITS-1:0]   pend_data, disp_data;
   logic [DIGITS-1:0]     pend_mask, disp_mask, eff_mask;
   logic [3:0]            dec_nib;
   logic [6:0]            dec_seg;
   logic                  dig_on;
   logic [DIGITS-1:0]     sel_idx;
   logic [6:0]            seg_d;
   logic [DIGITS-1:0]     sel_d;
   logic                  div_last, boundary, commit, xfer;

   assign upd_ready = !pend_vld;
   assign xfer      = upd_valid && !pend_vld;
   assign div_last  = (div_cnt == DIV_LAST);
   assign boundary  = div_last && (idx == IDX_LAST);
   assign commit    = boundary && pend_vld;

   // Suppression is folded into the stored mask so the scan path stays a plain lookup.
`ifdef SEG_SCAN_LZS_EN
   logic lead;
   always_comb begin
      eff_mask = pend_mask;
      lead     = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (pend_mask[i] && (pend_data[4*i +: 4] != 4'h0)) lead = 1'b0;
         if (lead) eff_mask[i] = 1'b0;
      end
   end
`else
   assign eff_mask = pend_mask;
`endif

   always_comb begin
      dec_nib = 4'h0;
      dig_on  = 1'b0;
      sel_idx = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            dec_nib    = disp_data[4*i +: 4];
            dig_on     = disp_mask[i];
            sel_idx[i] = 1'b0;
         end
      end
   end

   bcd7seg u_dec (
      .nib (dec_nib),
      .seg (dec_seg)
   );

   always_comb begin
      state_d = state_q;
      seg_d   = 7'h7F;
      sel_d   = '1;
      if (commit) state_d = SCAN;
      // div_cnt==0 is the anti-ghosting dead slot
      if ((state_q == SCAN) && (div_cnt != '0) && dig_on) begin
         seg_d = dec_seg;
         sel_d = sel_idx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BLANK;
         div_cnt    <= '0;
         idx        <= '0;
         pend_vld   <= 1'b0;
         pend_data  <= '0;
         pend_mask  <= '0;
         disp_data  <= '0;
         disp_mask  <= '0;
         seg_out    <= 7'h7F;
         digit_sel  <= '1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_out    <= seg_d;
         digit_sel  <= sel_d;
         frame_done <= boundary;
         div_cnt    <= div_last ? '0 : div_cnt + 1'b1;
         if (div_last) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (commit) begin
            disp_data <= pend_data;
            disp_mask <= eff_mask;
            pend_vld  <= 1'b0;
         end else if (xfer) begin
            pend_data <= upd_data;
            pend_mask <= upd_mask;
            pend_vld  <= 1'b1;
         end
      end
   end
endmodule
